// File: rtl/sp_regfile_if.sv
// sp_regfile_if: bus bundle between the address mux / control and the scratchpad.
//   master: drives addr, rd_en, we, wdata, inc, dec; observes everything else.
//   slave : the register file itself.
//   addr    4-bit scratchpad index (0..6 stored, 7 = M, 8..15 reserved)
//   rd_en   registered read request      rdata  registered read data
//   we      write strobe                 wdata  write data
//   inc/dec INR/DCR strobes              busy   RMW sequence in progress
//   flag_z/flag_s/flag_p  flags of last INR/DCR result
//   reg_h/reg_l  live H and L contents   fault  one-cycle illegal-access pulse
interface sp_regfile_if #(
  parameter int unsigned DATA_W = 8
);
  logic [3:0]        addr;
  logic              rd_en;
  logic [DATA_W-1:0] rdata;
  logic              we;
  logic [DATA_W-1:0] wdata;
  logic              inc;
  logic              dec;
  logic              busy;
  logic              flag_z;
  logic              flag_s;
  logic              flag_p;
  logic [DATA_W-1:0] reg_h;
  logic [DATA_W-1:0] reg_l;
  logic              fault;

  modport master (
    output addr, rd_en, we, wdata, inc, dec,
    input  rdata, busy, flag_z, flag_s, flag_p, reg_h, reg_l, fault
  );

  modport slave (
    input  addr, rd_en, we, wdata, inc, dec,
    output rdata, busy, flag_z, flag_s, flag_p, reg_h, reg_l, fault
  );
endinterface

// File: rtl/sp_regfile.sv
// sp_regfile: i8008 scratchpad register file (A,B,C,D,E,H,L).
//   clk1   single clock, all state changes on rising edge
//   rst_n  synchronous active-low reset
//   bus    sp_regfile_if slave: registered reads, writes, INR/DCR read-modify-write
//          with Z/S/P flag generation, live H/L outputs and an illegal-access pulse.
module sp_regfile #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned NREGS  = 7
) (
  input  logic         clk1,
  input  logic         rst_n,
  sp_regfile_if.slave  bus
);

  localparam int unsigned IdxW = $clog2(NREGS);
  localparam int unsigned HIdx = 5;
  localparam int unsigned LIdx = 6;
  localparam logic [DATA_W-1:0] One = DATA_W'(1);

  typedef enum logic [1:0] {StIdle, StRd, StWb} state_e;

  state_e            state_q;
  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] tmp_q;
  logic [IdxW-1:0]   idx_q;
  logic              op_inc_q;
  logic              busy_q;
  logic              flag_z_q, flag_s_q, flag_p_q;
  logic              fault_q;

  logic              addr_ok;   // index has backing storage
  logic              illegal;   // reserved index 8..15
  logic              access;
  logic              idle;
  logic              wr_go;
  logic              rmw_go;
  logic [IdxW-1:0]   aidx;
  logic [DATA_W-1:0] rd_val;
  logic [DATA_W-1:0] rmw_res;

  always_comb begin
    addr_ok = ({28'd0, bus.addr} < NREGS[31:0]);
    illegal = bus.addr[3];
    access  = bus.rd_en | bus.we | bus.inc | bus.dec;
    idle    = (state_q == StIdle);
    aidx    = bus.addr[IdxW-1:0];
    wr_go   = bus.we && idle;
    // A write in the same cycle wins over INR/DCR; M and reserved indices never sequence.
    rmw_go  = idle && !bus.we && (bus.inc ^ bus.dec) && addr_ok;
    rd_val  = addr_ok ? regs_q[aidx] : '0;
    rmw_res = op_inc_q ? (tmp_q + One) : (tmp_q - One);
  end

  always_ff @(posedge clk1) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
      rdata_q  <= '0;
      tmp_q    <= '0;
      idx_q    <= '0;
      op_inc_q <= 1'b0;
      busy_q   <= 1'b0;
      flag_z_q <= 1'b0;
      flag_s_q <= 1'b0;
      flag_p_q <= 1'b0;
      fault_q  <= 1'b0;
      state_q  <= StIdle;
    end else begin
      fault_q <= (access && illegal) || (idle && bus.inc && bus.dec);

      // Same-cycle write is forwarded so the read never sees the stale value.
      if (bus.rd_en) begin
        rdata_q <= (wr_go && addr_ok) ? bus.wdata : rd_val;
      end
      if (wr_go && addr_ok) begin
        regs_q[aidx] <= bus.wdata;
      end

      unique case (state_q)
        StIdle: begin
          if (rmw_go) begin
            idx_q    <= aidx;
            op_inc_q <= bus.inc;
            busy_q   <= 1'b1;
            state_q  <= StRd;
          end
        end
        StRd: begin
          tmp_q   <= regs_q[idx_q];
          state_q <= StWb;
        end
        StWb: begin
          regs_q[idx_q] <= rmw_res;
          flag_z_q      <= (rmw_res == '0);
          flag_s_q      <= rmw_res[DATA_W-1];
          flag_p_q      <= ~^rmw_res;
          busy_q        <= 1'b0;
          state_q       <= StIdle;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus.rdata  = rdata_q;
  assign bus.busy   = busy_q;
  assign bus.flag_z = flag_z_q;
  assign bus.flag_s = flag_s_q;
  assign bus.flag_p = flag_p_q;
  assign bus.reg_h  = regs_q[HIdx];
  assign bus.reg_l  = regs_q[LIdx];
  assign bus.fault  = fault_q;

endmodule
